// File: rtl/tdm_slot_collector.sv
// TDM slot collector: steps the mux select across SLOTS channels, samples din on the
// last dwell cycle of each slot, and offers the frame on a valid/ready handshake.
// Optional macro TDM_PARITY_EN adds a registered frame_par output.
module tdm_slot_collector #(
  parameter int unsigned SLOTS = 4,
  parameter int unsigned SEL_W = 2,
  parameter int unsigned DWELL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             din,
  input  logic             frame_ready,
`ifdef TDM_PARITY_EN
  output logic             frame_par,
`endif
  output logic [SEL_W-1:0] sel_out,
  output logic             busy,
  output logic [SLOTS-1:0] frame,
  output logic             frame_valid,
  output logic [7:0]       frame_cnt
);

  localparam int unsigned DWELL_W = 8;
  localparam logic [SEL_W-1:0]   LAST_SLOT  = SEL_W'(SLOTS - 1);
  localparam logic [DWELL_W-1:0] LAST_DWELL = DWELL_W'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  state_t             state;
  logic [SEL_W-1:0]   slot;
  logic [DWELL_W-1:0] dwell;
  logic [SLOTS-1:0]   frame_upd;

  // Current frame with the bit of the active slot replaced by din
  always_comb begin
    frame_upd       = frame;
    frame_upd[slot] = din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      slot        <= '0;
      dwell       <= '0;
      sel_out     <= '0;
      busy        <= 1'b0;
      frame       <= '0;
      frame_valid <= 1'b0;
      frame_cnt   <= '0;
`ifdef TDM_PARITY_EN
      frame_par   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= SCAN;
            slot    <= '0;
            dwell   <= '0;
            frame   <= '0;
            sel_out <= '0;
            busy    <= 1'b1;
          end
        end
        SCAN: begin
          if (dwell == LAST_DWELL) begin
            frame <= frame_upd;
            dwell <= '0;
            if (slot == LAST_SLOT) begin
              state       <= HOLD;
              busy        <= 1'b0;
              frame_valid <= 1'b1;
`ifdef TDM_PARITY_EN
              frame_par   <= ^frame_upd;
`endif
            end else begin
              slot    <= slot + SEL_W'(1);
              sel_out <= slot + SEL_W'(1);
            end
          end else begin
            dwell <= dwell + DWELL_W'(1);
          end
        end
        HOLD: begin
          // Frame is held until accepted; start only counts alongside a handshake
          if (frame_ready) begin
            frame_cnt   <= frame_cnt + 8'd1;
            frame_valid <= 1'b0;
            if (start) begin
              state   <= SCAN;
              slot    <= '0;
              dwell   <= '0;
              frame   <= '0;
              sel_out <= '0;
              busy    <= 1'b1;
            end else begin
              state   <= IDLE;
              sel_out <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
